// File: rtl/ysyx_25040109_arb_pkg.sv
// rtl/ysyx_25040109_arb_pkg.sv - shared types and constants for the IFU/LSU AXI arbiter
//
// Purpose: FSM state encoding, master index constants and AXI response codes
//          used by ysyx_25040109_axi_arbiter and ysyx_25040109_rr_arb2.
// Ports:   none (package).
package ysyx_25040109_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFU_RD = 2'd1,
        ST_LSU_RD = 2'd2,
        ST_LSU_WR = 2'd3
    } arb_state_e;

    // Bit positions in the two-entry request/grant vectors.
    localparam int unsigned MST_IFU = 0;
    localparam int unsigned MST_LSU = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_25040109_rr_arb2.sv
// rtl/ysyx_25040109_rr_arb2.sv - two-way round-robin grant with registered last-grant pointer
//
// Purpose: grants one of two requesters; on a tie the one not granted last wins.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req[1:0]   requests, bit MST_IFU / bit MST_LSU
//   en         grant enable; the pointer only moves on an enabled grant
//   gnt[1:0]   one-hot grant (zero when disabled or no request)
//   ptr_q      index of the requester granted last (reset: IFU, so LSU wins the first tie)
module ysyx_25040109_rr_arb2
    import ysyx_25040109_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr_q
);

    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) begin
                // Tie: favour whoever was not granted last.
                gnt = ptr_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
            if (gnt != 2'b00) begin
                ptr_d = gnt[MST_LSU];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ysyx_25040109_axi_arbiter.sv
// rtl/ysyx_25040109_axi_arbiter.sv - two-master (IFU read, LSU read/write) to one-slave AXI4 arbiter
//
// Purpose: owns the memory port for one whole transaction at a time (AR..last R
//          beat, or AW/W..B), forwarding the owner's channels combinationally and
//          forcing every non-owner output to zero.
// Build option: YSYX_25040109_ARB_LSU_PRIO_EN - when defined, LSU always beats
//          the IFU (fixed priority, no round-robin pointer).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ifu_ar*/ifu_r*  IFU read address / read data
//   lsu_ar*/lsu_r*  LSU read address / read data
//   lsu_aw*/lsu_w*/lsu_b*  LSU write address / data / response
//   mem_*           slave-side port toward the memory wrapper
module ysyx_25040109_axi_arbiter
    import ysyx_25040109_arb_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // IFU read
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [31:0]         ifu_araddr,
    input  logic [ID_W-1:0]     ifu_arid,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    input  logic [1:0]          ifu_arburst,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic [ID_W-1:0]     ifu_rid,
    output logic                ifu_rlast,
    // LSU read
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [31:0]         lsu_araddr,
    input  logic [ID_W-1:0]     lsu_arid,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    input  logic [1:0]          lsu_arburst,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic [ID_W-1:0]     lsu_rid,
    output logic                lsu_rlast,
    // LSU write
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [31:0]         lsu_awaddr,
    input  logic [ID_W-1:0]     lsu_awid,
    input  logic [7:0]          lsu_awlen,
    input  logic [2:0]          lsu_awsize,
    input  logic [1:0]          lsu_awburst,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [1:0]          lsu_bresp,
    output logic [ID_W-1:0]     lsu_bid,
    // Memory slave port
    output logic                mem_arvalid,
    input  logic                mem_arready,
    output logic [31:0]         mem_araddr,
    output logic [ID_W-1:0]     mem_arid,
    output logic [7:0]          mem_arlen,
    output logic [2:0]          mem_arsize,
    output logic [1:0]          mem_arburst,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic [ID_W-1:0]     mem_rid,
    input  logic                mem_rlast,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [31:0]         mem_awaddr,
    output logic [ID_W-1:0]     mem_awid,
    output logic [7:0]          mem_awlen,
    output logic [2:0]          mem_awsize,
    output logic [1:0]          mem_awburst,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wlast,
    input  logic                mem_bvalid,
    output logic                mem_bready,
    input  logic [1:0]          mem_bresp,
    input  logic [ID_W-1:0]     mem_bid
);

    arb_state_e state_q, state_d;
    logic [1:0] req;
    logic [1:0] gnt;

    // An LSU request is either direction; the write/read choice is made after
    // the LSU wins, so write-over-read never competes with the IFU pointer.
    assign req[MST_IFU] = ifu_arvalid;
    assign req[MST_LSU] = lsu_arvalid | lsu_awvalid;

`ifdef YSYX_25040109_ARB_LSU_PRIO_EN
    assign gnt = (state_q != ST_IDLE) ? 2'b00 :
                 req[MST_LSU]         ? 2'b10 :
                 req[MST_IFU]         ? 2'b01 : 2'b00;
`else
    // The pointer is exported for observation only; the grant is all we need.
    logic rr_ptr_unused;

    ysyx_25040109_rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .en    (state_q == ST_IDLE),
        .gnt   (gnt),
        .ptr_q (rr_ptr_unused)
    );
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt[MST_LSU]) begin
                    state_d = lsu_awvalid ? ST_LSU_WR : ST_LSU_RD;
                end else if (gnt[MST_IFU]) begin
                    state_d = ST_IFU_RD;
                end
            end
            ST_IFU_RD, ST_LSU_RD: begin
                if (mem_rvalid && mem_rready && mem_rlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LSU_WR: begin
                if (mem_bvalid && mem_bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Channel routing: everything defaults to zero so IDLE and the non-owner
    // see quiet, all-zero channels.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rid     = '0;
        ifu_rlast   = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rid     = '0;
        lsu_rlast   = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = '0;
        lsu_bid     = '0;
        mem_arvalid = 1'b0;
        mem_araddr  = '0;
        mem_arid    = '0;
        mem_arlen   = '0;
        mem_arsize  = '0;
        mem_arburst = '0;
        mem_rready  = 1'b0;
        mem_awvalid = 1'b0;
        mem_awaddr  = '0;
        mem_awid    = '0;
        mem_awlen   = '0;
        mem_awsize  = '0;
        mem_awburst = '0;
        mem_wvalid  = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wlast   = 1'b0;
        mem_bready  = 1'b0;
        case (state_q)
            ST_IFU_RD: begin
                mem_arvalid = ifu_arvalid;
                mem_araddr  = ifu_araddr;
                mem_arid    = ifu_arid;
                mem_arlen   = ifu_arlen;
                mem_arsize  = ifu_arsize;
                mem_arburst = ifu_arburst;
                ifu_arready = mem_arready;
                ifu_rvalid  = mem_rvalid;
                ifu_rdata   = mem_rdata;
                ifu_rresp   = mem_rresp;
                ifu_rid     = mem_rid;
                ifu_rlast   = mem_rlast;
                mem_rready  = ifu_rready;
            end
            ST_LSU_RD: begin
                mem_arvalid = lsu_arvalid;
                mem_araddr  = lsu_araddr;
                mem_arid    = lsu_arid;
                mem_arlen   = lsu_arlen;
                mem_arsize  = lsu_arsize;
                mem_arburst = lsu_arburst;
                lsu_arready = mem_arready;
                lsu_rvalid  = mem_rvalid;
                lsu_rdata   = mem_rdata;
                lsu_rresp   = mem_rresp;
                lsu_rid     = mem_rid;
                lsu_rlast   = mem_rlast;
                mem_rready  = lsu_rready;
            end
            ST_LSU_WR: begin
                mem_awvalid = lsu_awvalid;
                mem_awaddr  = lsu_awaddr;
                mem_awid    = lsu_awid;
                mem_awlen   = lsu_awlen;
                mem_awsize  = lsu_awsize;
                mem_awburst = lsu_awburst;
                lsu_awready = mem_awready;
                mem_wvalid  = lsu_wvalid;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wlast   = lsu_wlast;
                lsu_wready  = mem_wready;
                lsu_bvalid  = mem_bvalid;
                lsu_bresp   = mem_bresp;
                lsu_bid     = mem_bid;
                mem_bready  = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ysyx_25040109_axi_arbiter.md
# ysyx_25040109_axi_arbiter

Two-master, one-slave AXI4 arbiter that shares the single-port memory path between the IFU (read-only) and the LSU (read/write). It sits between the core's fetch/load-store units and the queued memory wrapper. It grants one complete transaction at a time, from address through last beat or write response, and routes responses back to the owning master.

## Interface
- ID_W, 4, AXI ID width on all channels
- DATA_W, 32, data width; address fixed at 32
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_ar{valid,ready,addr,id,len,size,burst}  in/out(ready)  1/1/32/ID_W/8/3/2  IFU read address
- ifu_r{valid,ready,data,resp,id,last}  out/in(ready)  1/1/DATA_W/2/ID_W/1  IFU read data
- lsu_ar* / lsu_r*  same widths as IFU  LSU read channels
- lsu_aw{valid,ready,addr,id,len,size,burst}  in/out(ready)  1/1/32/ID_W/8/3/2  LSU write address
- lsu_w{valid,ready,data,strb,last}  in/out(ready)  1/1/DATA_W/4/1  LSU write data
- lsu_b{valid,ready,resp,id}  out/in(ready)  1/1/2/ID_W  LSU write response
- mem_ar* / mem_r* / mem_aw* / mem_w* / mem_b*  mirrored directions  same widths  slave port to the memory wrapper

## Operation
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR.
- IDLE: no ready asserted toward any master; all mem_*valid low. Requests: IFU = ifu_arvalid, LR = lsu_arvalid, LW = lsu_awvalid.
- Grant in IDLE:
  - The LSU write has priority over the LSU read.
  - Between IFU and LSU, a round-robin pointer picks the requester not granted last.
  - With a single requester, that requester wins.
  - The pointer updates on grant.
- Read states (IFU_RD/LSU_RD):
  - The owner's AR and R channels connect combinationally to mem_ar/mem_r.
  - The other master sees arready=0 and rvalid=0.
  - Exit to IDLE on the cycle after mem_rvalid && mem_rready && mem_rlast.
- LSU_WR:
  - lsu_aw and lsu_w connect to mem_aw and mem_w; lsu_b connects to mem_b.
  - The AW and W handshakes may complete in either order or in the same cycle.
  - Exit on mem_bvalid && mem_bready.
- Non-owner outputs are forced to zero: data, resp, id, last.
- Unmapped response codes pass through unchanged. The arbiter never generates error responses.
- R beats with mismatched IDs are forwarded anyway. The ID is not checked.

## Timing
- Reset: state IDLE, RR pointer = IFU-last (LSU wins the first tie). All ready/valid outputs are 0 and all data outputs are 0.
- Grant latency: a request seen in IDLE at cycle N makes the channel live at N+1. The earliest arready to the master is at N+1.
- Turnaround: exactly one IDLE cycle between transactions.
- All forwarding in granted states is zero-latency and combinational. The arbiter adds no buffering.
- A master that drops valid before its handshake in the granted state is a protocol violation. The FSM holds the state and waits.
- Reset mid-transaction returns to IDLE in one cycle. The in-flight beat is discarded.

## Configuration
- YSYX_25040109_ARB_LSU_PRIO_EN:
  - Defined: fixed priority. LSU (write, then read) always beats the IFU, and the RR pointer is removed.
  - Undefined: round-robin as above.

## Structure
- Package ysyx_25040109_arb_pkg holds:
  - the FSM state enum (2 bits)
  - master index constants (IFU=0, LSU=1)
  - AXI resp constants (OKAY=2'b00, SLVERR=2'b10)
- Sub-module ysyx_25040109_rr_arb2: a 2-way round-robin grant. Inputs are two requests and an enable; outputs are a one-hot grant and the registered pointer.

## Test plan
- IFU-only read, len=0, addr 0x8000_0000: ifu_arready at cycle 1, ifu_r data returned with rlast, then one IDLE cycle. LSU channels stay idle.
- Simultaneous ifu_arvalid and lsu_arvalid from reset: LSU granted first, IFU granted after the LSU rlast plus one idle cycle, next tie goes to LSU again.
- LSU write with W valid two cycles before AW, data 0xDEADBEEF, strb 4'hF: both handshakes complete, bresp=OKAY forwarded, state returns to IDLE.
- LSU read and write requested together: write completes through B before the read AR is issued.
- IFU burst len=3: four R beats forwarded, state exits only after the beat with rlast=1. A lsu_arvalid raised mid-burst sees arready=0 until the burst finishes.
- Assert rst during LSU_RD with rvalid pending: all outputs are 0 the next cycle and state is IDLE. With YSYX_25040109_ARB_LSU_PRIO_EN defined, repeated ties all grant to the LSU.
